// File: rtl/mult_div_pkg.sv
// Shared opcode and state encodings for the iterative multiply/divide sequencer.
package mult_div_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration: Booth step for MULT, restoring step for DIV (on magnitudes).
module md_step
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_op,
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q1
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shl;
  logic [WIDTH:0] w_trial;

  always_comb begin
    w_sum   = i_acc;
    w_shl   = '0;
    w_trial = '0;
    o_acc   = i_acc;
    o_q     = i_q;
    o_q1    = i_q1;
    if (i_op == OP_MULT) begin
      case ({i_q[0], i_q1})
        2'b01:   w_sum = i_acc + i_m;
        2'b10:   w_sum = i_acc - i_m;
        default: w_sum = i_acc;
      endcase
      o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
      o_q   = {w_sum[0], i_q[WIDTH-1:1]};
      o_q1  = i_q[0];
    end else begin
      // Remainder stays below the divisor, so its top bit is free to act as the borrow.
      w_shl   = {i_acc[WIDTH-1:0], i_q[WIDTH-1]};
      w_trial = w_shl - i_m;
      if (!w_trial[WIDTH]) begin
        o_acc = w_trial;
        o_q   = {i_q[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = w_shl;
        o_q   = {i_q[WIDTH-2:0], 1'b0};
      end
      o_q1 = 1'b0;
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multiply/divide sequencer: command FSM, operand latches, sign fix-up and HI/LO ownership.
module mult_div_ctrl
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state, w_state_n;
  logic             r_busy, r_done, r_div_zero;
  logic             w_busy_n, w_done_n, w_div_zero_n;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op, r_neg_q, r_neg_r;
  logic [WIDTH:0]   r_acc, r_m;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH:0]   w_acc_n;
  logic [WIDTH-1:0] w_q_n;
  logic             w_q1_n;
  logic [WIDTH-1:0] w_hi_fix, w_lo_fix;
  logic             w_last;

  md_step #(.WIDTH(WIDTH)) u_step (
    .i_op  (r_op),
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_q1  (r_q1),
    .i_m   (r_m),
    .o_acc (w_acc_n),
    .o_q   (w_q_n),
    .o_q1  (w_q1_n)
  );

  assign w_last = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_div_zero <= w_div_zero_n;
    end
  end

  // Next state plus the flag values that will be visible in that state.
  always_comb begin
    w_state_n    = r_state;
    w_div_zero_n = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_DIV && op_b == '0) begin
            w_state_n    = S_DONE;
            w_div_zero_n = 1'b1;
          end else begin
            w_state_n = S_RUN;
          end
        end
      end
      S_RUN:   if (w_last) w_state_n = S_DONE;
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
    w_busy_n = (w_state_n != S_IDLE);
    w_done_n = (w_state_n == S_DONE);
  end

  // Sign fix-up applied to the final iteration's outputs.
  always_comb begin
    w_hi_fix = w_acc_n[WIDTH-1:0];
    w_lo_fix = w_q_n;
    if (r_op == OP_DIV) begin
      w_lo_fix = r_neg_q ? -w_q_n : w_q_n;
      w_hi_fix = r_neg_r ? -w_acc_n[WIDTH-1:0] : w_acc_n[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_op    <= OP_MULT;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_acc   <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (hi_we) r_hi <= wr_data;
          if (lo_we) r_lo <= wr_data;
          if (start) begin
            r_op  <= op;
            r_cnt <= '0;
            r_acc <= '0;
            r_q1  <= 1'b0;
            if (op == OP_MULT) begin
              r_q     <= op_b;
              r_m     <= {op_a[WIDTH-1], op_a};
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_q     <= op_a[WIDTH-1] ? -op_a : op_a;
              r_m     <= {1'b0, (op_b[WIDTH-1] ? -op_b : op_b)};
              r_neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
              r_neg_r <= op_a[WIDTH-1];
            end
          end
        end
        S_RUN: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_q1  <= w_q1_n;
          if (w_last) begin
            r_cnt <= '0;
            r_hi  <= w_hi_fix;
            r_lo  <= w_lo_fix;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: commands push expected HI/LO, a monitor checks on done.
module tb_mult_div_ctrl;
  import mult_div_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned due;
    int unsigned busy_len;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned busy_run = 0;

  mult_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: pops the oldest expectation whenever done is seen.
  always @(negedge clk) begin
    if (reset) begin
      if (busy) busy_run++;
      chk("dz_without_done", {31'b0, div_zero & ~done}, 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("hi", hi, mon_e.hi);
          chk("lo", lo, mon_e.lo);
          chk("div_zero", {31'b0, div_zero}, {31'b0, mon_e.dz});
          chk("latency", cyc, mon_e.due);
          chk("busy_len", busy_run, mon_e.busy_len);
        end
      end
      if (!busy) busy_run = 0;
    end else begin
      busy_run = 0;
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("idle_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic push_exp(input logic [31:0] eh, input logic [31:0] el, input logic edz);
    exp_t e;
    e.hi       = eh;
    e.lo       = el;
    e.dz       = edz;
    e.due      = cyc + (edz ? 1 : 33);
    e.busy_len = edz ? 1 : 33;
    sb.push_back(e);
  endtask

  task automatic cmd(input logic o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input logic edz,
                     input logic hwe, input logic lwe, input logic [31:0] wd);
    @(negedge clk);
    push_exp(eh, el, edz);
    start = 1'b1; op = o; op_a = a; op_b = b;
    hi_we = hwe; lo_we = lwe; wr_data = wd;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op_a = $urandom; op_b = $urandom; wr_data = $urandom;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dz", {31'b0, div_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;

    cmd(OP_MULT, 32'd6, 32'd7, 32'h0, 32'h2A, 1'b0, 1'b0, 1'b0, 32'h0);
    cmd(OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b0, 32'h0);
    cmd(OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    cmd(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0);
    cmd(OP_MULT, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0, 1'b0, 1'b0, 32'h0);
    cmd(OP_MULT, 32'h7FFFFFFF, 32'd2, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 32'h0);
    cmd(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 32'h0);
    cmd(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h0);
    cmd(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0, 32'h0);
    cmd(OP_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 32'h0);

    // MTHI / MTLO in IDLE, then divide-by-zero leaves them untouched.
    @(negedge clk); hi_we = 1'b1; wr_data = 32'h11;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h22;
    @(negedge clk); lo_we = 1'b0;
    chk("mthi", hi, 32'h11);
    chk("mtlo", lo, 32'h22);
    cmd(OP_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1'b0, 1'b0, 32'h0);
    cmd(OP_DIV, 32'd9, 32'd0, 32'h11, 32'h55, 1'b1, 1'b0, 1'b1, 32'h55);

    // Reset mid-MULT: discarded, no done pulse afterwards.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle", {31'b0, busy}, 32'd0);

    // Restart and register writes while busy are ignored.
    @(negedge clk);
    push_exp(32'h0, 32'd6, 1'b0);
    start = 1'b1; op = OP_MULT; op_a = 32'd2; op_b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op_b = 32'd9; op_a = 32'd5; hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("busy_write_hi", hi, 32'h0);
    chk("busy_write_lo", lo, 32'h0);
    wait_idle();

    // Write and start in the same cycle: write lands, result overwrites at completion.
    @(negedge clk);
    push_exp(32'h0, 32'h2A, 1'b0);
    start = 1'b1; op = OP_MULT; op_a = 32'd6; op_b = 32'd7; hi_we = 1'b1; wr_data = 32'hABCD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("same_cycle_mthi", hi, 32'hABCD);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
